// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared definitions for the MEM-stage data-memory access unit.
//   DMEM_ADDR_W : default data-memory word-address width (matches EXE/MEM dmem_addr)
//   ma_state_t  : access sequencer states (IDLE, REQ, WAIT_R, DONE)
package mem_access_unit_pkg;

    localparam int DMEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        MA_IDLE   = 2'd0,
        MA_REQ    = 2'd1,
        MA_WAIT_R = 2'd2,
        MA_DONE   = 2'd3
    } ma_state_t;

endpackage

// File: rtl/mem_access_timer.sv
// mem_access_timer: watchdog cycle counter for an outstanding data-memory access.
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clear   in  restart the count from zero (access is being launched)
//   enable  in  access in flight; count one cycle
//   limit   in  number of in-flight cycles allowed (>= 1)
//   expired out high in the in-flight cycle that uses up the limit
module mem_access_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    // count holds the number of in-flight cycles already completed, so the
    // cycle in which count+1 equals limit is the last one allowed
    assign count_inc = count + CNT_W'(1);
    assign expired   = enable && !clear && (count_inc == limit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer. Turns the instruction held in
// EXE/MEM into one req/gnt/rvalid transaction, stalls the upstream pipeline until
// it completes and returns registered load data to MEM/WB.
//   clk, rst                      clock, synchronous active-high reset
//   valid_in, mem_read_in,
//   mem_write_in, dmem_addr_in,
//   dmem_in_in                    instruction fields from EXE/MEM
//   stall_out                     combinational hold for PC, IF/ID, ID/EXE, EXE/MEM
//   mem_req, mem_we, mem_addr,
//   mem_wdata                     request to data memory (fields latched at start)
//   mem_gnt, mem_rvalid, mem_rdata  data-memory responses
//   load_data_out                 registered load result
//   done_out                      one-cycle pulse when an access finishes
//   err_out                       one-cycle pulse when an access times out
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to enable the watchdog
// (TIMEOUT_CYCLES in-flight cycles); without it err_out is tied 0.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W         = DMEM_ADDR_W,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [ADDR_W-1:0] dmem_addr_in,
    input  logic [DATA_W-1:0] dmem_in_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] load_data_out,
    output logic              done_out,
    output logic              err_out
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT_CYCLES must be >= 1");
    end

    ma_state_t state;
    ma_state_t state_next;
    logic      start;
    logic      load_capture;
    logic      timer_expired;

    assign start     = (state == MA_IDLE) && valid_in && (mem_read_in || mem_write_in);
    // DONE does not stall: EXE/MEM advances past the finished instruction at its end
    assign stall_out = start || (state == MA_REQ) || (state == MA_WAIT_R);
    assign mem_req   = (state == MA_REQ);
    assign done_out  = (state == MA_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MA_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_capture = 1'b0;
        case (state)
            MA_IDLE: begin
                if (start) state_next = MA_REQ;
            end
            MA_REQ: begin
                if (mem_gnt) begin
                    state_next = mem_we ? MA_DONE : MA_WAIT_R;
                end else if (timer_expired) begin
                    state_next = MA_DONE;
                end
            end
            MA_WAIT_R: begin
                if (mem_rvalid) begin
                    load_capture = 1'b1;
                    state_next   = MA_DONE;
                end else if (timer_expired) begin
                    state_next = MA_DONE;
                end
            end
            MA_DONE: begin
                state_next = MA_IDLE;
            end
            default: begin
                state_next = MA_IDLE;
            end
        endcase
    end

    // Request fields are latched at start so they stay stable while EXE/MEM is held;
    // a read+write instruction is issued as a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            load_data_out <= '0;
        end else begin
            if (start) begin
                mem_we    <= mem_write_in;
                mem_addr  <= dmem_addr_in;
                mem_wdata <= dmem_in_in;
            end
            if (load_capture) begin
                load_data_out <= mem_rdata;
            end
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic timer_run;
    logic timeout_hit;
    logic err_q;

    assign timer_run   = (state == MA_REQ) || (state == MA_WAIT_R);
    // a real completion in the last allowed cycle takes precedence over the timeout
    assign timeout_hit = timer_expired &&
                         (((state == MA_REQ) && !mem_gnt) || ((state == MA_WAIT_R) && !mem_rvalid));

    mem_access_timer #(
        .CNT_W (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .enable  (timer_run),
        .limit   (TIMER_W'(TIMEOUT_CYCLES)),
        .expired (timer_expired)
    );

    // registered so the pulse lines up with the DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign err_out = err_q;
`else
    assign timer_expired = 1'b0;
    assign err_out       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit.
// Table-driven directed vectors, hand-written reset/timeout sequences, then random
// instruction streams checked against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic              mem_read_in;
    logic              mem_write_in;
    logic [ADDR_W-1:0] dmem_addr_in;
    logic [DATA_W-1:0] dmem_in_in;
    logic              stall_out;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] load_data_out;
    logic              done_out;
    logic              err_out;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .dmem_addr_in  (dmem_addr_in),
        .dmem_in_in    (dmem_in_in),
        .stall_out     (stall_out),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .load_data_out (load_data_out),
        .done_out      (done_out),
        .err_out       (err_out)
    );

    typedef struct {
        logic              valid;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                req_cycles;   // REQ cycles until gnt (gnt in the last one)
        int                wait_cycles;  // WAIT_R cycles until rvalid (rvalid in the last one)
        int                exp_stall;
        int                exp_req;
        logic [DATA_W-1:0] exp_load;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] dev_mem [0:1023];  // memory behind the port, written from DUT requests
    logic [DATA_W-1:0] ref_mem [0:1023];  // reference memory, written from the instruction stream
    logic [DATA_W-1:0] ref_load;          // expected load_data_out

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one instruction at posedge+1 and plays the memory until the pipeline
    // advances; returns at posedge+1 of the cycle after the instruction retires.
    task automatic run_instr(input vec_t in, output int stall_cnt, output int req_cnt,
                             output int done_cnt, output int done_idx, output int err_cnt,
                             output int field_err, output logic [DATA_W-1:0] done_load,
                             output bit hung);
        int                req_seen;
        int                wait_seen;
        bit                granted;
        bit                is_wr;
        bit                retire;
        logic [ADDR_W-1:0] gnt_addr;
        req_seen  = 0;
        wait_seen = 0;
        granted   = 0;
        is_wr     = in.wr;
        gnt_addr  = '0;
        stall_cnt = 0;
        req_cnt   = 0;
        done_cnt  = 0;
        done_idx  = -1;
        err_cnt   = 0;
        field_err = 0;
        done_load = '0;
        hung      = 1;
        valid_in     = in.valid;
        mem_read_in  = in.rd;
        mem_write_in = in.wr;
        dmem_addr_in = in.addr;
        dmem_in_in   = in.data;
        for (int cyc = 0; cyc < 64; cyc++) begin
            #1;
            mem_rdata = $urandom;
            if (mem_req) begin
                req_seen++;
                req_cnt++;
                if (mem_addr !== in.addr || mem_we !== is_wr || (is_wr && mem_wdata !== in.data))
                    field_err++;
                if (req_seen == in.req_cycles) begin
                    mem_gnt  = 1'b1;
                    granted  = 1;
                    gnt_addr = mem_addr;
                    if (mem_we) dev_mem[mem_addr] = mem_wdata;
                end else begin
                    mem_rvalid = 1'($urandom_range(0, 1));
                end
            end else if (granted && !is_wr && wait_seen < in.wait_cycles) begin
                wait_seen++;
                mem_gnt = 1'($urandom_range(0, 1));
                if (wait_seen == in.wait_cycles) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = dev_mem[gnt_addr];
                end
            end else begin
                mem_gnt    = 1'($urandom_range(0, 1));
                mem_rvalid = 1'($urandom_range(0, 1));
            end
            #1;
            if (stall_out) stall_cnt++;
            if (done_out) begin
                done_cnt++;
                done_idx  = cyc;
                done_load = load_data_out;
            end
            if (err_out) err_cnt++;
            retire = !stall_out;
            @(posedge clk);
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (retire) begin
                hung = 0;
                break;
            end
        end
    endtask

    task automatic apply_and_check(input vec_t v, input string tag);
        int                stall_cnt, req_cnt, done_cnt, done_idx, err_cnt, field_err;
        logic [DATA_W-1:0] done_load;
        bit                hung;
        bit                is_mem, is_ld;
        is_mem = v.valid && (v.rd || v.wr);
        is_ld  = is_mem && !v.wr;
        run_instr(v, stall_cnt, req_cnt, done_cnt, done_idx, err_cnt, field_err, done_load, hung);
        check({tag, " hung"}, 64'(hung), 64'(0));
        check({tag, " stall cycles"}, 64'(stall_cnt), 64'(v.exp_stall));
        check({tag, " req cycles"}, 64'(req_cnt), 64'(v.exp_req));
        check({tag, " done pulses"}, 64'(done_cnt), 64'(is_mem ? 1 : 0));
        if (is_mem) check({tag, " done cycle"}, 64'(done_idx), 64'(v.exp_stall));
        check({tag, " err pulses"}, 64'(err_cnt), 64'(0));
        check({tag, " req fields"}, 64'(field_err), 64'(0));
        if (is_ld) check({tag, " load in DONE"}, 64'(done_load), 64'(v.exp_load));
        check({tag, " load after"}, 64'(load_data_out), 64'(v.exp_load));
    endtask

    // Reference: each instruction's cost and effect from the interface rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   is_mem, is_st;
        r      = v;
        is_mem = v.valid && (v.rd || v.wr);
        is_st  = is_mem && v.wr;
        if (!is_mem) begin
            r.exp_stall = 0;
            r.exp_req   = 0;
        end else if (is_st) begin
            r.exp_stall = 1 + v.req_cycles;
            r.exp_req   = v.req_cycles;
            ref_mem[v.addr] = v.data;
        end else begin
            r.exp_stall = 1 + v.req_cycles + v.wait_cycles;
            r.exp_req   = v.req_cycles;
            ref_load    = ref_mem[v.addr];
        end
        r.exp_load = ref_load;
        return r;
    endfunction

    initial begin
        vec_t vecs [12];
        vec_t v;
        int   req_cnt;
        bit   seen_done;
        logic [DATA_W-1:0] held;

        for (int i = 0; i < 1024; i++) begin
            dev_mem[i] = 32'hA5A5_0000 ^ DATA_W'(i);
            ref_mem[i] = 32'hA5A5_0000 ^ DATA_W'(i);
        end
        dev_mem[16] = 32'h1234_5678;
        ref_mem[16] = 32'h1234_5678;
        ref_load    = '0;

        // valid rd wr addr data req wait exp_stall exp_req exp_load
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 10'h004, 32'hCAFE_F00D, 1, 1, 2, 1, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 10'h010, 32'h0000_0000, 3, 2, 6, 3, 32'h1234_5678};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 10'h011, 32'h1111_1111, 1, 1, 0, 0, 32'h1234_5678};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 10'h012, 32'h2222_2222, 1, 1, 0, 0, 32'h1234_5678};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 10'h013, 32'h3333_3333, 1, 1, 0, 0, 32'h1234_5678};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'h014, 32'h4444_4444, 1, 1, 0, 0, 32'h1234_5678};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 10'h015, 32'h5555_5555, 1, 1, 0, 0, 32'h1234_5678};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 10'h016, 32'h6666_6666, 1, 1, 0, 0, 32'h1234_5678};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 10'h004, 32'h0000_0000, 1, 1, 3, 1, 32'hCAFE_F00D};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 10'h010, 32'h0000_0000, 2, 1, 4, 2, 32'h1234_5678};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 10'h020, 32'hDEAD_BEEF, 1, 1, 2, 1, 32'h1234_5678};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 10'h020, 32'h0000_0000, 1, 3, 5, 1, 32'hDEAD_BEEF};

        rst = 1'b1;
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        dmem_addr_in = '0; dmem_in_in = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset stall_out", 64'(stall_out), 64'(0));
        check("reset mem_req", 64'(mem_req), 64'(0));
        check("reset mem_we", 64'(mem_we), 64'(0));
        check("reset mem_addr", 64'(mem_addr), 64'(0));
        check("reset mem_wdata", 64'(mem_wdata), 64'(0));
        check("reset load_data_out", 64'(load_data_out), 64'(0));
        check("reset done_out", 64'(done_out), 64'(0));
        check("reset err_out", 64'(err_out), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            v = model(vecs[i]);
            check($sformatf("vec%0d model agrees with table", i), 64'(v.exp_stall), 64'(vecs[i].exp_stall));
            apply_and_check(vecs[i], $sformatf("vec%0d", i));
        end

        // reset while waiting for read data abandons the access
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; dmem_addr_in = 10'h020;
        @(posedge clk); #1;
        check("rstseq mem_req in REQ", 64'(mem_req), 64'(1));
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("rstseq mem_req in WAIT_R", 64'(mem_req), 64'(0));
        check("rstseq stall in WAIT_R", 64'(stall_out), 64'(1));
        rst = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstseq stall after", 64'(stall_out), 64'(0));
        check("rstseq mem_req after", 64'(mem_req), 64'(0));
        check("rstseq load after", 64'(load_data_out), 64'(0));
        check("rstseq done after", 64'(done_out), 64'(0));
        ref_load = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check("rstseq stale rvalid ignored", 64'(load_data_out), 64'(0));

        // random instruction streams against the reference model
        for (int n = 0; n < 200; n++) begin
            v.valid       = ($urandom_range(0, 9) != 0);
            v.rd          = 1'($urandom_range(0, 1));
            v.wr          = ($urandom_range(0, 2) == 0);
            v.addr        = ADDR_W'($urandom_range(0, 7));
            v.data        = $urandom;
            v.req_cycles  = $urandom_range(1, 3);
            v.wait_cycles = $urandom_range(1, 3);
            v = model(v);
            apply_and_check(v, $sformatf("rnd%0d", n));
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        // no gnt ever: watchdog ends the access after TMO cycles in REQ
        held = load_data_out;
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; dmem_addr_in = 10'h030;
        @(posedge clk); #1;
        req_cnt   = 0;
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (done_out) begin
                seen_done = 1;
                check("tmo err_out in DONE", 64'(err_out), 64'(1));
                check("tmo mem_req in DONE", 64'(mem_req), 64'(0));
                check("tmo stall in DONE", 64'(stall_out), 64'(0));
                @(posedge clk); #1;
                break;
            end
            if (mem_req) req_cnt++;
            @(posedge clk); #1;
        end
        check("tmo done seen", 64'(seen_done), 64'(1));
        check("tmo REQ cycles", 64'(req_cnt), 64'(TMO));
        valid_in = 1'b0; mem_read_in = 1'b0;
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFEED_FACE;
        repeat (2) @(posedge clk);
        #1;
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        check("tmo late rvalid ignored", 64'(load_data_out), 64'(held));
        check("tmo err after", 64'(err_out), 64'(0));
        check("tmo done after", 64'(done_out), 64'(0));
`else
        held = load_data_out;
        req_cnt = 0;
        seen_done = 0;
        check("idle load stable", 64'(held), 64'(ref_load));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
